// File: rtl/dsp_wb_master.sv
// Wishbone B3 classic master serving the DSP memory-request handshake.
// One request at a time; completion is signalled by active falling.
module dsp_wb_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] address,
  input  logic          start,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic [dw-1:0] data_rd,
  output logic          active,
  output logic          error,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          w_timeout;
  logic          w_fail;
  logic          w_done;

  // Error has priority over ack; timeout only fires when the slave is silent.
  assign w_timeout = (TIMEOUT != 0) && (r_count == LAST);
  assign w_fail    = wb_err_i || (!wb_ack_i && w_timeout);
  assign w_done    = wb_err_i || wb_ack_i || w_timeout;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      data_rd  <= '0;
      active   <= 1'b0;
      error    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            wb_adr_o <= address;
            wb_dat_o <= data_wr;
            wb_sel_o <= selection;
            wb_we_o  <= write;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            active   <= 1'b1;
            error    <= 1'b0;
            r_count  <= '0;
            r_state  <= BUS;
          end
        end
        BUS: begin
          if (w_done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            active   <= 1'b0;
            error    <= w_fail;
            if (!wb_we_o) begin
              data_rd <= w_fail ? '0 : wb_dat_i;
            end
            r_state  <= RELEASE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        RELEASE: begin
          // Wait for the initiator to drop start so a fast ack is not re-issued.
          if (!start) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_wb_master.sv
// Directed testbench for dsp_wb_master with a hand-driven Wishbone slave.
module tb_dsp_wb_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] address;
  logic        start;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        active;
  logic        error;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int checks = 0;
  int errors = 0;

  int          activeCycles;
  int          cycCycles;
  int          weCycles;
  logic [31:0] seenAdr;
  logic [31:0] seenDat;
  logic [3:0]  seenSel;
  logic        seenErrFirst;
  int          heldCyc;

  always #5 wb_clk = ~wb_clk;

  dsp_wb_master #(.dw(32), .aw(32), .TIMEOUT(8)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .address  (address),
    .start    (start),
    .selection(selection),
    .write    (write),
    .data_wr  (data_wr),
    .data_rd  (data_rd),
    .active   (active),
    .error    (error),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request, answer it after 'waits' silent cycles, and record bus activity.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] sel, input logic we,
                               input logic [31:0] data, input int waits, input logic [31:0] rdat,
                               input logic doAck, input logic doErr);
    address   = addr;
    selection = sel;
    write     = we;
    data_wr   = data;
    start     = 1'b1;
    @(posedge wb_clk); #1;
    start        = 1'b0;
    address      = ~addr;
    data_wr      = ~data;
    seenErrFirst = error;
    activeCycles = 0;
    cycCycles    = 0;
    weCycles     = 0;
    for (int n = 1; n <= 40 && active; n++) begin
      activeCycles++;
      if (wb_cyc_o && wb_stb_o) cycCycles++;
      if (wb_we_o) weCycles++;
      seenAdr = wb_adr_o;
      seenDat = wb_dat_o;
      seenSel = wb_sel_o;
      if (n == waits + 1) begin
        wb_ack_i = doAck;
        wb_err_i = doErr;
        wb_dat_i = rdat;
      end
      @(posedge wb_clk); #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
    if (active) checkOutput("bound", {31'b0, active}, 32'd0);
    @(posedge wb_clk); #1;
  endtask

  initial begin
    wb_rst    = 1'b1;
    address   = '0;
    start     = 1'b0;
    selection = '0;
    write     = 1'b0;
    data_wr   = '0;
    wb_dat_i  = '0;
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    checkOutput("rst_active", {31'b0, active}, 32'd0);
    checkOutput("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    checkOutput("rst_data_rd", data_rd, 32'd0);
    checkOutput("rst_adr", wb_adr_o, 32'd0);
    checkOutput("rst_error", {31'b0, error}, 32'd0);
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;

    // Zero-wait read
    applyStimulus(32'h0000_0024, 4'hF, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1, 1'b0);
    checkOutput("rd0_active", activeCycles, 1);
    checkOutput("rd0_cyc", cycCycles, 1);
    checkOutput("rd0_we", weCycles, 0);
    checkOutput("rd0_adr", seenAdr, 32'h0000_0024);
    checkOutput("rd0_data", data_rd, 32'h1234_5678);
    checkOutput("rd0_error", {31'b0, error}, 32'd0);

    // Write with 3 wait states; read data must not move
    applyStimulus(32'h0000_0100, 4'h4, 1'b1, 32'h00AB_0000, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checkOutput("wr_active", activeCycles, 4);
    checkOutput("wr_cyc", cycCycles, 4);
    checkOutput("wr_we", weCycles, 4);
    checkOutput("wr_dat", seenDat, 32'h00AB_0000);
    checkOutput("wr_sel", {28'b0, seenSel}, 32'h4);
    checkOutput("wr_adr", seenAdr, 32'h0000_0100);
    checkOutput("wr_data_rd", data_rd, 32'h1234_5678);
    checkOutput("idle_dat_hold", wb_dat_o, 32'h00AB_0000);
    checkOutput("idle_we", {31'b0, wb_we_o}, 32'd0);

    // Start held after a zero-wait completion
    address   = 32'h60;
    selection = 4'hF;
    write     = 1'b0;
    start     = 1'b1;
    @(posedge wb_clk); #1;
    checkOutput("held_accept", {31'b0, active}, 32'd1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1111_2222;
    @(posedge wb_clk); #1;
    wb_ack_i = 1'b0;
    checkOutput("held_done", {31'b0, active}, 32'd0);
    checkOutput("held_data", data_rd, 32'h1111_2222);
    heldCyc = 0;
    repeat (5) begin
      if (wb_cyc_o || active) heldCyc++;
      @(posedge wb_clk); #1;
    end
    checkOutput("held_single", heldCyc, 0);
    start = 1'b0;
    @(posedge wb_clk); #1;
    checkOutput("held_gap", {31'b0, active}, 32'd0);
    start = 1'b1;
    @(posedge wb_clk); #1;
    checkOutput("held_reaccept", {31'b0, active}, 32'd1);
    start    = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h3333_4444;
    @(posedge wb_clk); #1;
    wb_ack_i = 1'b0;
    checkOutput("held_data2", data_rd, 32'h3333_4444);
    @(posedge wb_clk); #1;

    // Silent slave: timeout after 8 cycles
    applyStimulus(32'h0000_0040, 4'hF, 1'b0, 32'h0, 0, 32'h7777_7777, 1'b0, 1'b0);
    checkOutput("to_active", activeCycles, 8);
    checkOutput("to_error", {31'b0, error}, 32'd1);
    checkOutput("to_data", data_rd, 32'd0);

    // Next request clears the error
    applyStimulus(32'h0000_0044, 4'hF, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 1'b1, 1'b0);
    checkOutput("clr_error_accept", {31'b0, seenErrFirst}, 32'd0);
    checkOutput("clr_active", activeCycles, 3);
    checkOutput("clr_data", data_rd, 32'hCAFE_F00D);

    // Err and ack together
    applyStimulus(32'h0000_0048, 4'hF, 1'b0, 32'h0, 1, 32'h55AA_55AA, 1'b1, 1'b1);
    checkOutput("err_active", activeCycles, 2);
    checkOutput("err_error", {31'b0, error}, 32'd1);
    checkOutput("err_data", data_rd, 32'd0);

    // Reset during the 2nd wait state, then a late ack
    applyStimulus(32'h0000_004C, 4'hF, 1'b0, 32'h0, 0, 32'h0000_0099, 1'b1, 1'b0);
    address = 32'h90;
    start   = 1'b1;
    @(posedge wb_clk); #1;
    start = 1'b0;
    checkOutput("rm_accept", {31'b0, active}, 32'd1);
    @(posedge wb_clk); #1;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    checkOutput("rm_cyc", {31'b0, wb_cyc_o}, 32'd0);
    checkOutput("rm_stb", {31'b0, wb_stb_o}, 32'd0);
    checkOutput("rm_active", {31'b0, active}, 32'd0);
    checkOutput("rm_data", data_rd, 32'd0);
    checkOutput("rm_adr", wb_adr_o, 32'd0);
    wb_rst   = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    @(posedge wb_clk); #1;
    wb_ack_i = 1'b0;
    checkOutput("late_ack_active", {31'b0, active}, 32'd0);
    checkOutput("late_ack_data", data_rd, 32'd0);

    // Normal read after reset
    applyStimulus(32'h0000_0080, 4'h3, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 1'b0);
    checkOutput("post_active", activeCycles, 1);
    checkOutput("post_data", data_rd, 32'h0BAD_F00D);
    checkOutput("post_error", {31'b0, error}, 32'd0);
    checkOutput("post_sel", {28'b0, seenSel}, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_wb_master.md
# dsp_wb_master

Responder end of the DSP block's internal memory-request handshake (`start`/`active`). Accepts one request at a time from the DSP state machine, runs it as a single Wishbone B3 classic master cycle on the system bus (RAM0 file descriptors and file data), and returns read data with completion signalled by `active` falling. A bus timeout and error reporting keep a dead slave from hanging the DSP state machine.

## Interface
Parameters:
- `dw`, 32, data width; must be 32, because `selection` is 4 byte lanes.
- `aw`, 32, address width.
- `TIMEOUT`, 1024, maximum cycles spent waiting for ack or err; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `wb_clk` in 1: system clock; all logic on rising edge.
- `wb_rst` in 1: synchronous active-high reset.
- `address` in aw: request byte address.
- `start` in 1: request strobe, level-sensitive, held by the initiator until it sees `active`.
- `selection` in 4: byte-lane enables.
- `write` in 1: 1 = write, 0 = read.
- `data_wr` in dw: write data, already lane-aligned.
- `data_rd` out dw: read data, valid from the cycle `active` falls; held until the next read completes.
- `active` out 1: high while a request is in flight.
- `error` out 1: last request ended by `wb_err_i` or timeout; cleared when the next request is accepted.
- `wb_adr_o` out aw: Wishbone address.
- `wb_dat_o` out dw: Wishbone write data.
- `wb_sel_o` out 4: Wishbone byte selects.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_stb_o` out 1: Wishbone strobe.
- `wb_dat_i` in dw: Wishbone read data.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_err_i` in 1: Wishbone error.

## Operation
- All outputs are registered.
- Reset values: every output is 0; the state is IDLE and the timeout counter is 0.
- **IDLE**
  - When `start`=1 at a clock edge: latch `address`/`selection`/`write`/`data_wr` onto `wb_adr_o`/`wb_sel_o`/`wb_we_o`/`wb_dat_o`.
  - On the same edge: set `wb_cyc_o`=`wb_stb_o`=1, `active`=1, `error`=0, clear the counter, and go to BUS.
  - Bus outputs are held at their last values while idle, except `wb_cyc_o`/`wb_stb_o`/`wb_we_o`, which are 0.
- **BUS**: the counter increments every cycle. Completion is checked in this priority order:
  1. `wb_err_i`=1: end the cycle with `error`=1; if a read, `data_rd`=0.
  2. `wb_ack_i`=1: end the cycle; if a read, `data_rd`=`wb_dat_i` (full 32 bits, unmasked); a write leaves `data_rd` unchanged.
  3. `TIMEOUT`≠0 and counter == `TIMEOUT`−1: end the cycle with `error`=1; if a read, `data_rd`=0.
- **End of cycle**: on the completing edge, `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0 and `active`=0, then go to RELEASE.
- **RELEASE**: return to IDLE on the first edge where `start`=0. This guards against the initiator still holding `start` after a fast ack, which would otherwise be double-issued.
- `address`/`data_wr` changing while in BUS has no effect; values were latched at acceptance.
- `wb_adr_o` passes through unmodified; byte-lane alignment is the initiator's responsibility.

## Timing
- Request accepted at edge E (`start` sampled high). `wb_cyc_o`/`wb_stb_o`/`active` are high from E.
- With a zero-wait slave acking in the first BUS cycle, completion occurs at edge E+1: `active` is high for exactly 1 cycle and `data_rd` is valid after E+1.
- General case: with N wait states, `active` is high for N+1 cycles.
- Minimum request-to-request spacing: RELEASE lasts ≥1 cycle, so the next `start` is accepted no earlier than 1 edge after `start` is seen low.
- Timeout: the cycle ends exactly `TIMEOUT` cycles after E.
- Reset mid-cycle: on the reset edge `wb_cyc_o`/`wb_stb_o`/`active` drop to 0 and no data is captured; a late `wb_ack_i` after reset is ignored (state is IDLE).
- `wb_ack_i` or `wb_err_i` while in IDLE or RELEASE: ignored.

## Test plan
- Read, zero-wait slave returning 0x1234_5678 at 0x0000_0024, sel=F: `wb_cyc_o`/`wb_stb_o` high 1 cycle with `wb_adr_o`=0x24 and `wb_we_o`=0; `active` pulses 1 cycle; `data_rd`=0x1234_5678; `error`=0.
- Write of 0x00AB_0000 with sel=4 and 3 wait states: `wb_dat_o`/`wb_sel_o`=0x00AB_0000/4 with `wb_we_o`=1 for 4 cycles; `active` high 4 cycles; `data_rd` unchanged.
- `start` held high 5 cycles after a zero-wait completion: exactly one Wishbone cycle is issued, and the next request is accepted only after `start` goes low.
- `TIMEOUT`=8 with a slave that never responds, on a read: the cycle is dropped 8 cycles after acceptance; `error`=1 and `data_rd`=0; the next request clears `error`.
- `wb_err_i` and `wb_ack_i` asserted together on a read: `error`=1 and `data_rd`=0.
- `wb_rst` asserted during the 2nd wait state: all outputs 0 on the next edge; a subsequent read completes normally.
